button_event_decoder: RTL and testbench

- Consumes the clean, single-bit level from the upstream debounce stage.
- Classifies button activity into one-cycle event pulses: press, release, short click, double click and long press.
- Feeds the project's LED and 7-segment control logic, so downstream logic never handles raw levels or timing.
- Single clock domain; the input is already synchronous and debounced.

---
 rtl/button_event_pkg.sv | 17 +
 rtl/button_event_decoder_if.sv | 33 +++
 rtl/edge_detect.sv | 26 ++
 rtl/button_event_decoder.sv | 123 ++++++++++++
 tb/tb_button_event_decoder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/button_event_pkg.sv
// Shared types for the button event decoder.
// State encoding plus a constant helper for sizing the hold/gap counter.
package button_event_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_LONG_HELD,
        S_WAIT_GAP,
        S_SECOND_PRESS
    } state_t;

    function automatic int max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, classified event pulses out.
// master drives the level, slave is the decoder side.
interface button_event_if;

    logic debounced;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic short_click;
    logic double_click;
    logic long_press;

    modport master (
        output debounced,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  short_click,
        input  double_click,
        input  long_press
    );

    modport slave (
        input  debounced,
        output pressed,
        output press_pulse,
        output release_pulse,
        output short_click,
        output double_click,
        output long_press
    );

endinterface

// File: rtl/edge_detect.sv
// Registered previous sample of a synchronous level plus
// combinational rise/fall strobes derived from it.
module edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall,
    output logic o_prev
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_prev;
    assign o_fall = ~i_sig & r_prev;
    assign o_prev = r_prev;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press, release,
// short-click, double-click and long-press pulses.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 12_500_000,
    parameter int DOUBLE_GAP_CYCLES = 6_250_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_debounced,
    output logic o_pressed,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_short_click,
    output logic o_double_click,
    output logic o_long_press
);

    localparam int CW = $clog2(max(LONG_PRESS_CYCLES, DOUBLE_GAP_CYCLES));
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_GAP_CYCLES - 1);

    logic w_rise;
    logic w_fall;
    logic w_prev;

    edge_detect u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_debounced),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_prev (w_prev)
    );

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            w_short;
    logic            w_double;
    logic            w_long;

    // Edges are tested before thresholds so an edge on the threshold cycle wins.
    always_comb begin
        w_next   = r_state;
        w_short  = 1'b0;
        w_double = 1'b0;
        w_long   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) w_next = S_PRESSED;
            end
            S_PRESSED: begin
                if (w_fall) begin
                    w_next = S_WAIT_GAP;
                end else if (r_cnt == LONG_LAST) begin
                    w_long = 1'b1;
                    w_next = S_LONG_HELD;
                end
            end
            S_LONG_HELD: begin
                if (w_fall) w_next = S_IDLE;
            end
            S_WAIT_GAP: begin
                if (w_rise) begin
                    w_next = S_SECOND_PRESS;
                end else if (r_cnt == GAP_LAST) begin
                    w_short = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_SECOND_PRESS: begin
                if (w_fall) begin
                    w_double = 1'b1;
                    w_next   = S_IDLE;
                end else if (r_cnt == LONG_LAST) begin
                    w_long = 1'b1;
                    w_next = S_LONG_HELD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    logic r_press;
    logic r_release;
    logic r_short;
    logic r_double;
    logic r_long;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_double  <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_press   <= w_rise;
            r_release <= w_fall;
            r_short   <= w_short;
            r_double  <= w_double;
            r_long    <= w_long;
        end
    end

    assign o_pressed       = w_prev;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_short_click   = r_short;
    assign o_double_click  = r_double;
    assign o_long_press    = r_long;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed and random button traffic against a timestamp-based
// reference model of the click classifier.
module tb_button_event_decoder;

    localparam int LONG = 8;
    localparam int GAP  = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    button_event_if bif ();

    button_event_decoder #(
        .LONG_PRESS_CYCLES (LONG),
        .DOUBLE_GAP_CYCLES (GAP)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_debounced     (bif.debounced),
        .o_pressed       (bif.pressed),
        .o_press_pulse   (bif.press_pulse),
        .o_release_pulse (bif.release_pulse),
        .o_short_click   (bif.short_click),
        .o_double_click  (bif.double_click),
        .o_long_press    (bif.long_press)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase plus timestamp of the edge that opened it.
    localparam int P_IDLE = 0;
    localparam int P_HOLD1 = 1;
    localparam int P_LONG = 2;
    localparam int P_GAP = 3;
    localparam int P_HOLD2 = 4;

    int   m_phase = P_IDLE;
    int   m_t0    = 0;
    int   m_now   = 0;
    logic m_prev  = 1'b0;
    int   e_pressed, e_press, e_rel, e_short, e_dbl, e_long;

    task automatic model_step(input logic r, input logic v);
        bit rise, fall;
        m_now++;
        e_short = 0;
        e_dbl   = 0;
        e_long  = 0;
        if (r) begin
            m_phase   = P_IDLE;
            m_prev    = 1'b0;
            e_pressed = 0;
            e_press   = 0;
            e_rel     = 0;
            return;
        end
        rise = v && !m_prev;
        fall = !v && m_prev;
        e_pressed = int'(v);
        e_press   = int'(rise);
        e_rel     = int'(fall);
        case (m_phase)
            P_IDLE: if (rise) begin m_phase = P_HOLD1; m_t0 = m_now; end
            P_HOLD1:
                if (fall) begin
                    m_phase = P_GAP; m_t0 = m_now;
                end else if (m_now - m_t0 == LONG) begin
                    e_long = 1; m_phase = P_LONG;
                end
            P_LONG: if (fall) m_phase = P_IDLE;
            P_GAP:
                if (rise) begin
                    m_phase = P_HOLD2; m_t0 = m_now;
                end else if (m_now - m_t0 == GAP) begin
                    e_short = 1; m_phase = P_IDLE;
                end
            P_HOLD2:
                if (fall) begin
                    e_dbl = 1; m_phase = P_IDLE;
                end else if (m_now - m_t0 == LONG) begin
                    e_long = 1; m_phase = P_LONG;
                end
            default: m_phase = P_IDLE;
        endcase
        m_prev = v;
    endtask

    int c_press, c_rel, c_short, c_dbl, c_long;

    task automatic clr_counts();
        c_press = 0; c_rel = 0; c_short = 0; c_dbl = 0; c_long = 0;
    endtask

    task automatic step(input logic r, input logic v);
        @(negedge clk);
        check("pressed", int'(bif.pressed), e_pressed);
        check("press_pulse", int'(bif.press_pulse), e_press);
        check("release_pulse", int'(bif.release_pulse), e_rel);
        check("short_click", int'(bif.short_click), e_short);
        check("double_click", int'(bif.double_click), e_dbl);
        check("long_press", int'(bif.long_press), e_long);
        check("one_class_event",
              int'((int'(bif.short_click) + int'(bif.double_click)
                    + int'(bif.long_press)) <= 1), 1);
        c_press += int'(bif.press_pulse);
        c_rel   += int'(bif.release_pulse);
        c_short += int'(bif.short_click);
        c_dbl   += int'(bif.double_click);
        c_long  += int'(bif.long_press);
        rst = r;
        bif.debounced = v;
        model_step(r, v);
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) step(1'b0, v);
    endtask

    task automatic chk_counts(input string tag, input int p, input int rl,
                              input int s, input int d, input int l);
        check({tag, ".press"}, c_press, p);
        check({tag, ".release"}, c_rel, rl);
        check({tag, ".short"}, c_short, s);
        check({tag, ".double"}, c_dbl, d);
        check({tag, ".long"}, c_long, l);
    endtask

    initial begin
        rst = 1'b1;
        bif.debounced = 1'b0;
        model_step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        hold(1'b0, 3);

        clr_counts();
        hold(1'b1, 3); hold(1'b0, 10);
        chk_counts("short", 1, 1, 1, 0, 0);

        clr_counts();
        hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 10);
        chk_counts("double", 2, 2, 0, 1, 0);

        clr_counts();
        hold(1'b1, 20); hold(1'b0, 10);
        chk_counts("long", 1, 1, 0, 0, 1);

        clr_counts();
        hold(1'b1, LONG); hold(1'b0, 10);
        chk_counts("fall_at_long", 1, 1, 1, 0, 0);

        clr_counts();
        hold(1'b1, 3); hold(1'b0, GAP); hold(1'b1, 12); hold(1'b0, 10);
        chk_counts("rise_at_gap", 2, 2, 0, 0, 1);

        clr_counts();
        hold(1'b1, 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        clr_counts();
        hold(1'b0, 12);
        chk_counts("reset_mid", 0, 0, 0, 0, 0);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)));
            end else begin
                hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
            end
        end
        hold(1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
